miriscv_mdu_issue: RTL and testbench
====================================

// Module: miriscv_mdu_issue
// PURPOSE
//  Execute-stage requester for miriscv_mdu: issues one MUL/DIV/REM op per valid instruction and drives req/kill/keep.
//  Holds operands stable for the whole op, consumes mdu stall/result, returns one registered result to the pipeline.
//  Stops a hung divide with a watchdog. Sits between decode/EX control and the MDU; owns no arithmetic.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max BUSY cycles before forced kill; must be >= worst-case divide latency + 2
// PORTS
//  clk_i               in   1         clock
//  arstn_i             in   1         async reset, active-low
//  ex_valid_i          in   1         EX holds a valid MDU instruction
//  ex_mdu_op_i         in   MDU_OP_W  opcode, miriscv_mdu_pkg encoding
//  ex_op_a_i           in   XLEN      rs1 value
//  ex_op_b_i           in   XLEN      rs2 value
//  ex_flush_i          in   1         pipeline flush; cancel everything in flight
//  wb_stall_i          in   1         downstream stage cannot accept a result this cycle
//  ex_result_o         out  XLEN      result, valid only with ex_result_valid_o
//  ex_result_valid_o   out  1         result handed downstream this cycle
//  ex_stall_o          out  1         freeze EX and earlier stages
//  timeout_o           out  1         one-cycle pulse: watchdog fired
//  mdu_req_o           out  1         to mdu_req_i
//  mdu_port_a_o        out  XLEN      to mdu_port_a_i
//  mdu_port_b_o        out  XLEN      to mdu_port_b_i
//  mdu_op_o            out  MDU_OP_W  to mdu_op_i
//  mdu_kill_o          out  1         to mdu_kill_i
//  mdu_keep_o          out  1         to mdu_keep_i
//  mdu_result_i        in   XLEN      from mdu_result_o
//  mdu_stall_req_i     in   1         from mdu_stall_req_o
// BEHAVIOUR
//  Reset: state IDLE, op/result regs 0, watchdog 0. All outputs 0.
//  States:
//   IDLE: operands route combinationally from ex_*_i.
//   BUSY: MDU is computing.
//   HOLD: result captured, waiting on wb_stall_i.
//  IDLE:
//   - issue = ex_valid_i & ~ex_flush_i. mdu_req_o=issue. Latch op/a/b into op regs.
//   - issue & ~mdu_stall_req_i (mul, or div done same cycle):
//       ~wb_stall_i -> ex_result_o=mdu_result_i, valid=1, stay IDLE;
//       else capture result -> HOLD.
//   - issue & mdu_stall_req_i -> BUSY, ex_stall_o=1.
//  BUSY:
//   - mdu_req_o=1; mdu_port_*/op driven from latched regs, never from ex_*_i.
//   - ex_stall_o=1. Watchdog increments each cycle.
//   - mdu_stall_req_i falls -> same-cycle handoff rule as IDLE
//     (valid and ex_stall_o=0 if ~wb_stall_i, else capture -> HOLD). Watchdog clears.
//  HOLD:
//   - mdu_req_o=0, mdu_keep_o=1 (MDU must not recompute). ex_stall_o=1.
//   - ex_result_o=result reg.
//   - ~wb_stall_i -> valid=1, ex_stall_o=0, -> IDLE.
//  Flush (any state, highest priority):
//   - mdu_kill_o=1 if state==BUSY or IDLE issue attempt; ex_result_valid_o=0.
//   - Next state IDLE, watchdog cleared. Flush in HOLD drops the captured result.
//  Watchdog: reaching TIMEOUT_CYCLES in BUSY -> mdu_kill_o=1, timeout_o=1, ex_result_valid_o=1 with result 0, -> IDLE.
//   Flush in the same cycle wins: no result, timeout_o still pulses.
//  Counter: $clog2(TIMEOUT_CYCLES+1) bits, saturates; no wrap.
//  At most one ex_result_valid_o per issued op. mdu_kill_o and mdu_keep_o never high together.
//  Reset mid-op: async return to IDLE; the MDU is reset by the same arstn_i.
// STRUCTURE
//  miriscv_mdu_pkg gains:
//   - typedef enum logic [1:0] {MDU_ISS_IDLE, MDU_ISS_BUSY, MDU_ISS_HOLD} mdu_iss_state_e;
//   - localparam MDU_ISS_TIMEOUT_DEFAULT = 64.
//  Reuses XLEN and MDU_OP_W/opcodes from the existing packages.
//  Single flat module, no sub-modules. Instantiated beside miriscv_mdu in the execute stage.
// TESTING (bench pairs DUT with real miriscv_mdu)
//  1 MUL a=7 b=-3, wb_stall_i=0 -> valid same cycle, result 0xFFFFFFEB, ex_stall_o never high
//  2 DIV a=100 b=7 -> BUSY while mdu stalls; one valid pulse result 14; mdu_port_* stable throughout
//    even if ex_op_a_i is toggled
//  3 REM a=100 b=7 with wb_stall_i high 3 cycles at completion -> HOLD, keep=1, req=0;
//    then valid once, result 2
//  4 DIVU a=0xFFFFFFFF b=0 -> result 0xFFFFFFFF; REMU same operands -> 0xFFFFFFFF
//  5 DIV in flight, ex_flush_i pulsed in BUSY -> kill=1 that cycle, no valid, next DIV 9/3 -> 3
//  6 TIMEOUT_CYCLES=4, forced stall_req=1 -> after 4 BUSY cycles kill=1, timeout_o=1, valid with 0, back to IDLE

Source files
------------

// File: rtl/miriscv_mdu_pkg.sv
// Shared MDU definitions: datapath width, opcode encoding and issue-FSM types.
package miriscv_mdu_pkg;

    localparam int XLEN     = 32;
    localparam int MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;

    localparam int MDU_ISS_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        MDU_ISS_IDLE,
        MDU_ISS_BUSY,
        MDU_ISS_HOLD
    } mdu_iss_state_e;

    function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
        return op >= MDU_DIV;
    endfunction

endpackage

// File: rtl/miriscv_mdu.sv
// Multiply/divide unit: single-cycle multiply, radix-2 restoring divide that
// raises mdu_stall_req_o until its result is ready.
module miriscv_mdu
    import miriscv_mdu_pkg::*;
(
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                mdu_req_i,
    input  logic [XLEN-1:0]     mdu_port_a_i,
    input  logic [XLEN-1:0]     mdu_port_b_i,
    input  logic [MDU_OP_W-1:0] mdu_op_i,
    input  logic                mdu_kill_i,
    input  logic                mdu_keep_i,
    output logic [XLEN-1:0]     mdu_result_o,
    output logic                mdu_stall_req_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic             r_busy, r_done, r_neg_q, r_neg_r, r_rem_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_quo, r_rem, r_div;

    logic             w_is_div, w_sgn, w_neg_a, w_neg_b, w_start, w_ge;
    logic [XLEN-1:0]  w_abs_a, w_abs_b, w_q, w_r;
    logic [XLEN:0]    w_rsh, w_sub;
    logic [XLEN:0]    w_a_ext, w_b_ext;
    logic [2*XLEN-1:0] w_prod;

    assign w_is_div = mdu_is_div(mdu_op_i);
    assign w_sgn    = ~mdu_op_i[0];
    assign w_neg_a  = w_sgn & mdu_port_a_i[XLEN-1];
    assign w_neg_b  = w_sgn & mdu_port_b_i[XLEN-1];
    assign w_abs_a  = w_neg_a ? -mdu_port_a_i : mdu_port_a_i;
    assign w_abs_b  = w_neg_b ? -mdu_port_b_i : mdu_port_b_i;
    assign w_start  = mdu_req_i & ~mdu_kill_i & ~mdu_keep_i & w_is_div & ~r_busy & ~r_done;

    assign mdu_stall_req_o = mdu_req_i & w_is_div & ~r_done;

    // One quotient bit per cycle on the operand magnitudes; signs fixed up at the output.
    assign w_rsh = {r_rem, r_quo[XLEN-1]};
    assign w_sub = w_rsh - {1'b0, r_div};
    assign w_ge  = ~w_sub[XLEN];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem_sel <= 1'b0;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
        end else if (mdu_kill_i) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (w_start) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_div     <= w_abs_b;
            r_neg_q   <= (w_neg_a ^ w_neg_b) & (|mdu_port_b_i);
            r_neg_r   <= w_neg_a;
            r_rem_sel <= mdu_op_i[1];
        end else if (r_busy) begin
            r_rem <= w_ge ? w_sub[XLEN-1:0] : w_rsh[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(XLEN-1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign w_q = r_neg_q ? -r_quo : r_quo;
    assign w_r = r_neg_r ? -r_rem : r_rem;

    assign w_a_ext = {(mdu_op_i != MDU_MULHU) & mdu_port_a_i[XLEN-1], mdu_port_a_i};
    assign w_b_ext = {(mdu_op_i == MDU_MULH) & mdu_port_b_i[XLEN-1], mdu_port_b_i};
    assign w_prod  = (2*XLEN)'($signed(w_a_ext) * $signed(w_b_ext));

    always_comb begin
        mdu_result_o = w_prod[XLEN-1:0];
        if (w_is_div)
            mdu_result_o = r_rem_sel ? w_r : w_q;
        else if (mdu_op_i != MDU_MUL)
            mdu_result_o = w_prod[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/miriscv_mdu_issue.sv
// Execute-stage requester for miriscv_mdu: issues one op per instruction, holds
// operands while the MDU stalls, and returns one result per op with a watchdog.
module miriscv_mdu_issue
    import miriscv_mdu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MDU_ISS_TIMEOUT_DEFAULT
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                ex_valid_i,
    input  logic [MDU_OP_W-1:0] ex_mdu_op_i,
    input  logic [XLEN-1:0]     ex_op_a_i,
    input  logic [XLEN-1:0]     ex_op_b_i,
    input  logic                ex_flush_i,
    input  logic                wb_stall_i,
    output logic [XLEN-1:0]     ex_result_o,
    output logic                ex_result_valid_o,
    output logic                ex_stall_o,
    output logic                timeout_o,
    output logic                mdu_req_o,
    output logic [XLEN-1:0]     mdu_port_a_o,
    output logic [XLEN-1:0]     mdu_port_b_o,
    output logic [MDU_OP_W-1:0] mdu_op_o,
    output logic                mdu_kill_o,
    output logic                mdu_keep_o,
    input  logic [XLEN-1:0]     mdu_result_i,
    input  logic                mdu_stall_req_i
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    mdu_iss_state_e      r_state, w_state_nxt;
    logic [MDU_OP_W-1:0] r_op;
    logic [XLEN-1:0]     r_a, r_b, r_result;
    logic [WD_W-1:0]     r_wdog;

    logic w_issue, w_busy, w_done, w_fire, w_capture;

    assign w_issue   = (r_state == MDU_ISS_IDLE) & ex_valid_i & ~ex_flush_i;
    assign w_busy    = (r_state == MDU_ISS_BUSY);
    assign w_done    = ~mdu_stall_req_i & (w_issue | w_busy);
    // The watchdog only fires on an op still stalling; a result arriving on the
    // deadline cycle is delivered normally.
    assign w_fire    = w_busy & mdu_stall_req_i & (r_wdog >= WD_W'(TIMEOUT_CYCLES));
    assign w_capture = w_done & wb_stall_i & ~ex_flush_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) r_state <= MDU_ISS_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ex_flush_i) begin
            w_state_nxt = MDU_ISS_IDLE;
        end else begin
            unique case (r_state)
                MDU_ISS_IDLE:
                    if (w_issue)
                        w_state_nxt = mdu_stall_req_i ? MDU_ISS_BUSY :
                                      (wb_stall_i ? MDU_ISS_HOLD : MDU_ISS_IDLE);
                MDU_ISS_BUSY:
                    if (w_fire)
                        w_state_nxt = MDU_ISS_IDLE;
                    else if (!mdu_stall_req_i)
                        w_state_nxt = wb_stall_i ? MDU_ISS_HOLD : MDU_ISS_IDLE;
                MDU_ISS_HOLD:
                    if (!wb_stall_i) w_state_nxt = MDU_ISS_IDLE;
                default:
                    w_state_nxt = MDU_ISS_IDLE;
            endcase
        end
    end

    always_comb begin
        mdu_req_o         = 1'b0;
        mdu_port_a_o      = r_a;
        mdu_port_b_o      = r_b;
        mdu_op_o          = r_op;
        mdu_kill_o        = 1'b0;
        mdu_keep_o        = 1'b0;
        ex_result_o       = '0;
        ex_result_valid_o = 1'b0;
        ex_stall_o        = 1'b0;
        timeout_o         = w_fire;
        unique case (r_state)
            MDU_ISS_IDLE: begin
                mdu_req_o    = w_issue;
                mdu_port_a_o = ex_op_a_i;
                mdu_port_b_o = ex_op_b_i;
                mdu_op_o     = ex_mdu_op_i;
                mdu_kill_o   = ex_flush_i & ex_valid_i;
                if (w_issue) begin
                    if (mdu_stall_req_i || wb_stall_i) begin
                        ex_stall_o = 1'b1;
                    end else begin
                        ex_result_o       = mdu_result_i;
                        ex_result_valid_o = 1'b1;
                    end
                end
            end
            MDU_ISS_BUSY: begin
                mdu_req_o  = 1'b1;
                ex_stall_o = 1'b1;
                if (ex_flush_i) begin
                    mdu_kill_o = 1'b1;
                    ex_stall_o = 1'b0;
                end else if (w_fire) begin
                    mdu_kill_o        = 1'b1;
                    ex_result_valid_o = 1'b1;
                    ex_stall_o        = 1'b0;
                end else if (!mdu_stall_req_i && !wb_stall_i) begin
                    ex_result_o       = mdu_result_i;
                    ex_result_valid_o = 1'b1;
                    ex_stall_o        = 1'b0;
                end
            end
            MDU_ISS_HOLD: begin
                mdu_keep_o  = 1'b1;
                ex_result_o = r_result;
                ex_stall_o  = 1'b1;
                if (ex_flush_i) begin
                    ex_stall_o = 1'b0;
                end else if (!wb_stall_i) begin
                    ex_result_valid_o = 1'b1;
                    ex_stall_o        = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_wdog   <= '0;
        end else begin
            if (w_issue) begin
                r_op <= ex_mdu_op_i;
                r_a  <= ex_op_a_i;
                r_b  <= ex_op_b_i;
            end
            if (w_capture)
                r_result <= mdu_result_i;
            if (ex_flush_i || w_state_nxt != MDU_ISS_BUSY)
                r_wdog <= '0;
            else if (w_busy && r_wdog < WD_W'(TIMEOUT_CYCLES))
                r_wdog <= r_wdog + 1'b1;
        end
    end

endmodule

// File: tb/tb_miriscv_mdu_issue.sv
// Scoreboard bench: issue unit paired with miriscv_mdu, plus a short-timeout
// instance whose MDU stall is held high to exercise the watchdog.
module tb_miriscv_mdu_issue;
    import miriscv_mdu_pkg::*;

    logic clk_i = 1'b0;
    logic arstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                ex_valid_i = 0, ex_flush_i = 0, wb_stall_i = 0;
    logic [MDU_OP_W-1:0] ex_mdu_op_i = '0;
    logic [XLEN-1:0]     ex_op_a_i = '0, ex_op_b_i = '0;
    logic [XLEN-1:0]     ex_result_o, mdu_port_a_o, mdu_port_b_o, w_mdu_result;
    logic                ex_result_valid_o, ex_stall_o, timeout_o;
    logic                mdu_req_o, mdu_kill_o, mdu_keep_o, w_mdu_stall;
    logic [MDU_OP_W-1:0] mdu_op_o;

    miriscv_mdu_issue dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .ex_valid_i(ex_valid_i), .ex_mdu_op_i(ex_mdu_op_i),
        .ex_op_a_i(ex_op_a_i), .ex_op_b_i(ex_op_b_i),
        .ex_flush_i(ex_flush_i), .wb_stall_i(wb_stall_i),
        .ex_result_o(ex_result_o), .ex_result_valid_o(ex_result_valid_o),
        .ex_stall_o(ex_stall_o), .timeout_o(timeout_o),
        .mdu_req_o(mdu_req_o), .mdu_port_a_o(mdu_port_a_o), .mdu_port_b_o(mdu_port_b_o),
        .mdu_op_o(mdu_op_o), .mdu_kill_o(mdu_kill_o), .mdu_keep_o(mdu_keep_o),
        .mdu_result_i(w_mdu_result), .mdu_stall_req_i(w_mdu_stall)
    );

    miriscv_mdu u_mdu (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .mdu_req_i(mdu_req_o), .mdu_port_a_i(mdu_port_a_o), .mdu_port_b_i(mdu_port_b_o),
        .mdu_op_i(mdu_op_o), .mdu_kill_i(mdu_kill_o), .mdu_keep_i(mdu_keep_o),
        .mdu_result_o(w_mdu_result), .mdu_stall_req_o(w_mdu_stall)
    );

    // Watchdog instance: MDU stall forced high, MDU result a nonzero junk value.
    logic                t_valid = 0, t_flush = 0, t_wb = 0, t_stall_in = 1'b1;
    logic [MDU_OP_W-1:0] t_op = '0, t_op_o;
    logic [XLEN-1:0]     t_a = '0, t_b = '0, t_res_in = 32'hDEAD_BEEF;
    logic [XLEN-1:0]     t_result, t_pa, t_pb;
    logic                t_valid_o, t_stall_o, t_timeout, t_req, t_kill, t_keep;

    miriscv_mdu_issue #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .ex_valid_i(t_valid), .ex_mdu_op_i(t_op),
        .ex_op_a_i(t_a), .ex_op_b_i(t_b),
        .ex_flush_i(t_flush), .wb_stall_i(t_wb),
        .ex_result_o(t_result), .ex_result_valid_o(t_valid_o),
        .ex_stall_o(t_stall_o), .timeout_o(t_timeout),
        .mdu_req_o(t_req), .mdu_port_a_o(t_pa), .mdu_port_b_o(t_pb),
        .mdu_op_o(t_op_o), .mdu_kill_o(t_kill), .mdu_keep_o(t_keep),
        .mdu_result_i(t_res_in), .mdu_stall_req_i(t_stall_in)
    );

    int n_cmp = 0, n_err = 0;
    logic [XLEN-1:0] q0[$], q1[$];
    logic [XLEN-1:0] e0, e1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Monitors: every result pulse must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (ex_result_valid_o) begin
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got %h expected no result", ex_result_o);
            end else begin
                e0 = q0.pop_front();
                n_cmp++;
                if (ex_result_o !== e0) begin
                    n_err++;
                    $display("FAIL result: got %h expected %h", ex_result_o, e0);
                end
            end
        end
        if (timeout_o) begin
            n_err++;
            $display("FAIL spurious_timeout: got 1 expected 0");
        end
        if ((mdu_kill_o && mdu_keep_o) || (t_kill && t_keep)) begin
            n_err++;
            $display("FAIL kill_keep_overlap: got both high expected exclusive");
        end
    end

    always @(negedge clk_i) begin
        if (t_valid_o) begin
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL wd_unexpected_valid: got %h expected no result", t_result);
            end else begin
                e1 = q1.pop_front();
                n_cmp++;
                if (t_result !== e1) begin
                    n_err++;
                    $display("FAIL wd_result: got %h expected %h", t_result, e1);
                end
            end
        end
    end

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit tgl);
        int  n = 0;
        bit  stable = 1'b1;
        ex_valid_i = 1; ex_mdu_op_i = op; ex_op_a_i = a; ex_op_b_i = b;
        q0.push_back(exp);
        @(negedge clk_i);
        while (ex_stall_o && n < 100) begin
            if (mdu_port_a_o !== a || mdu_port_b_o !== b || mdu_op_o !== op) stable = 1'b0;
            cyc();
            if (tgl) begin
                ex_op_a_i = ~ex_op_a_i;
                ex_op_b_i = ex_op_b_i + 1;
            end
            n++;
            @(negedge clk_i);
        end
        if (mdu_port_a_o !== a || mdu_port_b_o !== b || mdu_op_o !== op) stable = 1'b0;
        check({nm, "_bound"}, 32'(n < 100), 1);
        if (tgl) check({nm, "_ports_stable"}, 32'(stable), 1);
        cyc();
        ex_valid_i = 0; ex_op_a_i = '0; ex_op_b_i = '0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_result", ex_result_o, 0);
        check("reset_flags", {26'd0, ex_result_valid_o, ex_stall_o, timeout_o,
                              mdu_req_o, mdu_kill_o, mdu_keep_o}, 0);
        check("reset_wd_flags", {26'd0, t_valid_o, t_stall_o, t_timeout, t_req, t_kill, t_keep}, 0);
        cyc();
        arstn_i = 1;
        cyc();

        // Multiplies complete in the issue cycle with no stall.
        ex_valid_i = 1; ex_mdu_op_i = MDU_MUL; ex_op_a_i = 32'd7; ex_op_b_i = 32'hFFFF_FFFD;
        q0.push_back(32'hFFFF_FFEB);
        @(negedge clk_i);
        check("mul_no_stall", 32'(ex_stall_o), 0);
        check("mul_req", 32'(mdu_req_o), 1);
        cyc();
        ex_valid_i = 0;
        run_op("mulh", MDU_MULH, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_op("mulhu", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);

        // Divide with EX operands toggling underneath it.
        run_op("div100_7", MDU_DIV, 32'd100, 32'd7, 32'd14, 1);

        // REM completes into a stalled writeback: HOLD for two cycles, then release.
        wb_stall_i = 1; ex_valid_i = 1; ex_mdu_op_i = MDU_REM; ex_op_a_i = 32'd100; ex_op_b_i = 32'd7;
        q0.push_back(32'd2);
        n = 0;
        @(negedge clk_i);
        while (w_mdu_stall && n < 100) begin
            cyc(); n++;
            @(negedge clk_i);
        end
        check("rem_bound", 32'(n < 100), 1);
        check("rem_capture_no_valid", 32'(ex_result_valid_o), 0);
        check("rem_capture_stall", 32'(ex_stall_o), 1);
        for (int k = 0; k < 2; k++) begin
            cyc();
            @(negedge clk_i);
            check("hold_req", 32'(mdu_req_o), 0);
            check("hold_keep", 32'(mdu_keep_o), 1);
            check("hold_stall", 32'(ex_stall_o), 1);
            check("hold_no_valid", 32'(ex_result_valid_o), 0);
        end
        cyc();
        wb_stall_i = 0;
        @(negedge clk_i);
        check("hold_release_valid", 32'(ex_result_valid_o), 1);
        check("hold_release_stall", 32'(ex_stall_o), 0);
        cyc();
        ex_valid_i = 0;

        // Divide-by-zero and signed corner cases.
        run_op("divu_by0", MDU_DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("remu_by0", MDU_REMU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0);
        run_op("rem_neg", MDU_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);

        // Flush on an IDLE issue attempt: kill, no request, no result.
        ex_valid_i = 1; ex_mdu_op_i = MDU_DIV; ex_op_a_i = 32'd50; ex_op_b_i = 32'd5; ex_flush_i = 1;
        @(negedge clk_i);
        check("idle_flush_kill", 32'(mdu_kill_o), 1);
        check("idle_flush_req", 32'(mdu_req_o), 0);
        cyc();
        ex_flush_i = 0; ex_valid_i = 0;

        // Flush mid-divide: kill that cycle, no result, then a clean divide.
        ex_valid_i = 1; ex_mdu_op_i = MDU_DIV; ex_op_a_i = 32'd100; ex_op_b_i = 32'd7;
        repeat (5) cyc();
        @(negedge clk_i);
        check("busy_stall", 32'(ex_stall_o), 1);
        cyc();
        ex_flush_i = 1;
        @(negedge clk_i);
        check("busy_flush_kill", 32'(mdu_kill_o), 1);
        check("busy_flush_no_valid", 32'(ex_result_valid_o), 0);
        cyc();
        ex_flush_i = 0; ex_valid_i = 0;
        @(negedge clk_i);
        check("post_flush_idle", {30'd0, mdu_req_o, ex_stall_o}, 0);
        cyc();
        run_op("div9_3", MDU_DIV, 32'd9, 32'd3, 32'd3, 0);

        // Watchdog: issue cycle, four BUSY cycles, fire on the next.
        t_valid = 1; t_op = MDU_DIV; t_a = 32'd5; t_b = 32'd1;
        q1.push_back(32'd0);
        n = 0;
        @(negedge clk_i);
        while (!t_timeout && n < 20) begin
            cyc(); n++;
            @(negedge clk_i);
        end
        check("wd_fire_cycle", n, 5);
        check("wd_kill", 32'(t_kill), 1);
        check("wd_valid", 32'(t_valid_o), 1);
        check("wd_ports", {t_pa[15:0], t_pb[15:0]}, {16'd5, 16'd1});
        check("wd_op", 32'(t_op_o), 32'(MDU_DIV));
        cyc();
        t_valid = 0;
        @(negedge clk_i);
        check("wd_back_idle", {29'd0, t_stall_o, t_req, t_timeout}, 0);

        // Flush on the firing cycle: timeout still pulses, no result.
        cyc();
        t_valid = 1;
        repeat (5) cyc();
        t_flush = 1;
        @(negedge clk_i);
        check("wd_flush_timeout", 32'(t_timeout), 1);
        check("wd_flush_kill", 32'(t_kill), 1);
        check("wd_flush_no_valid", 32'(t_valid_o), 0);
        cyc();
        t_flush = 0; t_valid = 0;
        repeat (2) cyc();

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
